usb_desc_streamer: RTL and testbench

USB_DESC_STREAMER -- requirements
Module: usb_desc_streamer

---
 rtl/usb_desc_pkg.sv | 76 +++++++
 rtl/usb_desc_rom.sv | 37 +++
 rtl/usb_desc_streamer.sv | 256 +++++++++++++++++++++++++
 tb/tb_usb_desc_streamer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_desc_pkg.sv
// usb_desc_pkg
//   Shared definitions for the EP0 descriptor streamer: USB descriptor type
//   codes, descriptor header constants, the descriptor ROM image with its
//   offset/length table, and the streamer FSM state encoding.
package usb_desc_pkg;

   // bDescriptorType codes (wValue high byte of GET_DESCRIPTOR)
   typedef enum logic [7:0] {
      DESC_DEVICE           = 8'h01,
      DESC_CONFIGURATION    = 8'h02,
      DESC_STRING           = 8'h03,
      DESC_DEVICE_QUALIFIER = 8'h06
   } DescriptorType;

   // Header constants and descriptor placement inside the image
   localparam logic [15:0] DEVICE_DESC_LEN  = 16'd18;
   localparam logic [15:0] CONFIG_TOTAL_LEN = 16'd32;
   localparam logic [15:0] DEVICE_OFFSET    = 16'd0;
   localparam logic [15:0] CONFIG_OFFSET    = 16'd18;
   localparam int unsigned STRING_COUNT     = 4;
   localparam int unsigned DESC_IMAGE_SIZE  = 74;

   // Streamer FSM states
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOOKUP = 3'd1,
      S_FETCH  = 3'd2,
      S_STREAM = 3'd3,
      S_ZLP    = 3'd4,
      S_FINISH = 3'd5
   } stream_state_e;

   // Descriptor image: device (0), configuration set (18), strings 0..3 (50..73).
   // bMaxPacketSize0 (byte 7) reflects the default 8-byte EP0.
   localparam logic [7:0] DESC_IMAGE [DESC_IMAGE_SIZE] = '{
      // device descriptor
      8'h12, 8'h01, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h08, 8'h34,
      8'h12, 8'h78, 8'h56, 8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h01,
      // configuration + interface + two bulk endpoints (wTotalLength 32)
      8'h09, 8'h02, 8'h20, 8'h00, 8'h01, 8'h01, 8'h00, 8'h80, 8'h32,
      8'h09, 8'h04, 8'h00, 8'h00, 8'h02, 8'hFF, 8'h00, 8'h00, 8'h00,
      8'h07, 8'h05, 8'h81, 8'h02, 8'h40, 8'h00, 8'h00,
      8'h07, 8'h05, 8'h02, 8'h02, 8'h40, 8'h00, 8'h00,
      // string 0: LANGID 0x0409
      8'h04, 8'h03, 8'h09, 8'h04,
      // string 1: "AB"
      8'h06, 8'h03, 8'h41, 8'h00, 8'h42, 8'h00,
      // string 2: "USB"
      8'h08, 8'h03, 8'h55, 8'h00, 8'h53, 8'h00, 8'h42, 8'h00,
      // string 3: "X1"
      8'h06, 8'h03, 8'h58, 8'h00, 8'h31, 8'h00
   };

   // Start offset of string descriptor idx within the image
   function automatic logic [15:0] str_offset(input logic [7:0] idx);
      case (idx)
         8'd0:    return 16'd50;
         8'd1:    return 16'd54;
         8'd2:    return 16'd60;
         8'd3:    return 16'd68;
         default: return 16'd0;
      endcase
   endfunction

   // bLength of string descriptor idx
   function automatic logic [15:0] str_len(input logic [7:0] idx);
      case (idx)
         8'd0:    return 16'd4;
         8'd1:    return 16'd6;
         8'd2:    return 16'd8;
         8'd3:    return 16'd6;
         default: return 16'd0;
      endcase
   endfunction

endpackage

// File: rtl/usb_desc_rom.sv
// usb_desc_rom
//   Synchronous descriptor ROM, one-cycle read latency.
//   clk_i  : clock
//   addr_i : byte address
//   data_o : registered byte at the address presented on the previous edge
//            (zero beyond the end of the image)
module usb_desc_rom
   import usb_desc_pkg::*;
#(
   parameter int unsigned ADDR_W = 8
) (
   input  logic              clk_i,
   input  logic [ADDR_W-1:0] addr_i,
   output logic [7:0]        data_o
);

   localparam int unsigned DEPTH = 1 << ADDR_W;

   logic [7:0] mem_s [DEPTH];
   logic [7:0] data_q;

   for (genvar i = 0; i < DEPTH; i++) begin : g_mem
      if (i < DESC_IMAGE_SIZE) begin : g_img
         assign mem_s[i] = DESC_IMAGE[i];
      end else begin : g_pad
         assign mem_s[i] = 8'h00;
      end
   end

   // Registered read port
   always_ff @(posedge clk_i) begin
      data_q <= mem_s[addr_i];
   end

   assign data_o = data_q;

endmodule

// File: rtl/usb_desc_streamer.sv
// usb_desc_streamer
//   Serves GET_DESCRIPTOR requests on EP0: looks the descriptor up, streams
//   min(descLen, wLength) bytes split into EP0_MAX_PKT packets, requests a
//   trailing ZLP when the short transfer ends on a packet boundary, and
//   pulses done (or reqError for unsupported requests).
//   clk48/rst_n                  : clock, synchronous active-low reset
//   reqValid/reqReady/reqType/
//   reqIdx/reqLength             : request handshake and wValue/wLength
//   abort                        : new SETUP, cancels everything
//   byteValid/byteReady/byteData/
//   pktEnd                       : descriptor byte stream
//   zlpReq/zlpAck                : zero-length packet request
//   done/reqError                : completion / STALL pulses
module usb_desc_streamer
   import usb_desc_pkg::*;
#(
   parameter int unsigned EP0_MAX_PKT = 8,
   parameter int unsigned ROM_ADDR_W  = 8,
   parameter int unsigned NUM_STRINGS = 4
) (
   input  logic        clk48,
   input  logic        rst_n,
   input  logic        reqValid,
   output logic        reqReady,
   input  logic [7:0]  reqType,
   input  logic [7:0]  reqIdx,
   input  logic [15:0] reqLength,
   input  logic        abort,
   output logic        byteValid,
   input  logic        byteReady,
   output logic [7:0]  byteData,
   output logic        pktEnd,
   output logic        zlpReq,
   input  logic        zlpAck,
   output logic        done,
   output logic        reqError
);

   localparam logic [15:0] PKT_LAST = 16'(EP0_MAX_PKT - 1);
   localparam logic [15:0] PKT_MASK = 16'(EP0_MAX_PKT - 1);
   localparam logic [ROM_ADDR_W-1:0] ADDR_ONE = ROM_ADDR_W'(1);
   localparam logic [ROM_ADDR_W-1:0] ADDR_TWO = ROM_ADDR_W'(2);

   stream_state_e         state_q, state_d;
   logic [7:0]            type_q, type_d, idx_q, idx_d;
   logic [15:0]           len_q, len_d, total_q, total_d;
   logic [15:0]           sent_q, sent_d, pkt_q, pkt_d;
   logic [ROM_ADDR_W-1:0] ptr_q, ptr_d;
   logic                  byte_valid_q, byte_valid_d;
   logic [7:0]            byte_data_q, byte_data_d;
   logic                  pkt_end_q, pkt_end_d;
   logic                  zlp_req_q, zlp_req_d;
   logic                  done_q, done_d;
   logic                  req_error_q, req_error_d;

   logic                  desc_ok_s;
   logic [ROM_ADDR_W-1:0] start_s;
   logic [15:0]           desc_len_s, total_s;
   logic [ROM_ADDR_W-1:0] rd_addr_s;
   logic [7:0]            rom_data_s;
   logic                  xfer_s, last_s, zlp_needed_s;
   logic [15:0]           sent_inc_s, pkt_inc_s;

   usb_desc_rom #(.ADDR_W(ROM_ADDR_W)) u_rom (
      .clk_i  (clk48),
      .addr_i (rd_addr_s),
      .data_o (rom_data_s)
   );

   assign xfer_s       = byte_valid_q & byteReady;
   assign last_s       = (sent_q == (total_q - 16'd1));
   assign zlp_needed_s = (total_q < len_q) && ((total_q & PKT_MASK) == 16'd0);
   assign sent_inc_s   = sent_q + 16'd1;
   assign pkt_inc_s    = pkt_end_q ? 16'd0 : (pkt_q + 16'd1);

   // Descriptor table lookup and transfer length clamp
   always_comb begin
      desc_ok_s  = 1'b0;
      start_s    = '0;
      desc_len_s = 16'd0;
      case (type_q)
         DESC_DEVICE: begin
            if (idx_q == 8'd0) begin
               desc_ok_s  = 1'b1;
               start_s    = ROM_ADDR_W'(DEVICE_OFFSET);
               desc_len_s = DEVICE_DESC_LEN;
            end else begin
               desc_ok_s  = 1'b0;
            end
         end
         DESC_CONFIGURATION: begin
            if (idx_q == 8'd0) begin
               desc_ok_s  = 1'b1;
               start_s    = ROM_ADDR_W'(CONFIG_OFFSET);
               desc_len_s = CONFIG_TOTAL_LEN;
            end else begin
               desc_ok_s  = 1'b0;
            end
         end
         DESC_STRING: begin
            if ((32'(idx_q) < NUM_STRINGS) && (32'(idx_q) < STRING_COUNT)) begin
               desc_ok_s  = 1'b1;
               start_s    = ROM_ADDR_W'(str_offset(idx_q));
               desc_len_s = str_len(idx_q);
            end else begin
               desc_ok_s  = 1'b0;
            end
         end
         default: desc_ok_s = 1'b0;  // DEVICE_QUALIFIER lands here: FS-only device
      endcase
      total_s = (desc_len_s < len_q) ? desc_len_s : len_q;
   end

   // Next-state, counters, output register and ROM address
   always_comb begin
      state_d      = state_q;
      type_d       = type_q;
      idx_d        = idx_q;
      len_d        = len_q;
      total_d      = total_q;
      sent_d       = sent_q;
      pkt_d        = pkt_q;
      ptr_d        = ptr_q;
      byte_valid_d = byte_valid_q;
      byte_data_d  = byte_data_q;
      pkt_end_d    = pkt_end_q;
      zlp_req_d    = zlp_req_q;
      done_d       = 1'b0;
      req_error_d  = 1'b0;
      // Keep the byte after the one on the bus in flight from the ROM
      rd_addr_s    = ptr_q + ADDR_ONE;

      if (abort) begin
         state_d      = S_IDLE;
         byte_valid_d = 1'b0;
         pkt_end_d    = 1'b0;
         zlp_req_d    = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (reqValid) begin
                  type_d  = reqType;
                  idx_d   = reqIdx;
                  len_d   = reqLength;
                  state_d = S_LOOKUP;
               end else begin
                  state_d = S_IDLE;
               end
            end
            S_LOOKUP: begin
               rd_addr_s = start_s;
               ptr_d     = start_s;
               total_d   = total_s;
               sent_d    = 16'd0;
               pkt_d     = 16'd0;
               if (!desc_ok_s) begin
                  req_error_d = 1'b1;
                  state_d     = S_IDLE;
               end else if (total_s == 16'd0) begin
                  zlp_req_d   = 1'b1;
                  state_d     = S_ZLP;
               end else begin
                  state_d     = S_FETCH;
               end
            end
            S_FETCH: begin
               byte_data_d  = rom_data_s;
               byte_valid_d = 1'b1;
               pkt_end_d    = (PKT_LAST == 16'd0) || (total_q == 16'd1);
               state_d      = S_STREAM;
            end
            S_STREAM: begin
               if (xfer_s) begin
                  // ptr advances this edge, so the ROM must already fetch ptr+2
                  rd_addr_s = ptr_q + ADDR_TWO;
                  sent_d    = sent_inc_s;
                  pkt_d     = pkt_inc_s;
                  if (last_s) begin
                     byte_valid_d = 1'b0;
                     pkt_end_d    = 1'b0;
                     if (zlp_needed_s) begin
                        zlp_req_d = 1'b1;
                        state_d   = S_ZLP;
                     end else begin
                        done_d    = 1'b1;
                        state_d   = S_FINISH;
                     end
                  end else begin
                     ptr_d       = ptr_q + ADDR_ONE;
                     byte_data_d = rom_data_s;
                     pkt_end_d   = (pkt_inc_s == PKT_LAST) ||
                                   (sent_inc_s == (total_q - 16'd1));
                  end
               end else begin
                  state_d = S_STREAM;
               end
            end
            S_ZLP: begin
               if (zlpAck) begin
                  zlp_req_d = 1'b0;
                  done_d    = 1'b1;
                  state_d   = S_FINISH;
               end else begin
                  state_d   = S_ZLP;
               end
            end
            S_FINISH: state_d = S_IDLE;  // done_q is high during this state
            default:  state_d = S_IDLE;
         endcase
      end
   end

   // State and output registers
   always_ff @(posedge clk48) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         type_q       <= 8'h00;
         idx_q        <= 8'h00;
         len_q        <= 16'd0;
         total_q      <= 16'd0;
         sent_q       <= 16'd0;
         pkt_q        <= 16'd0;
         ptr_q        <= '0;
         byte_valid_q <= 1'b0;
         byte_data_q  <= 8'h00;
         pkt_end_q    <= 1'b0;
         zlp_req_q    <= 1'b0;
         done_q       <= 1'b0;
         req_error_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         type_q       <= type_d;
         idx_q        <= idx_d;
         len_q        <= len_d;
         total_q      <= total_d;
         sent_q       <= sent_d;
         pkt_q        <= pkt_d;
         ptr_q        <= ptr_d;
         byte_valid_q <= byte_valid_d;
         byte_data_q  <= byte_data_d;
         pkt_end_q    <= pkt_end_d;
         zlp_req_q    <= zlp_req_d;
         done_q       <= done_d;
         req_error_q  <= req_error_d;
      end
   end

   assign reqReady  = (state_q == S_IDLE);
   assign byteValid = byte_valid_q;
   assign byteData  = byte_data_q;
   assign pktEnd    = pkt_end_q;
   assign zlpReq    = zlp_req_q;
   assign done      = done_q;
   assign reqError  = req_error_q;

endmodule

// File: tb/tb_usb_desc_streamer.sv
// Directed testbench for usb_desc_streamer (EP0_MAX_PKT 8, NUM_STRINGS 4).
module tb_usb_desc_streamer;

   logic        clk48 = 1'b0;
   logic        rst_n = 1'b0;
   logic        reqValid = 1'b0;
   logic        reqReady;
   logic [7:0]  reqType = 8'h00;
   logic [7:0]  reqIdx = 8'h00;
   logic [15:0] reqLength = 16'd0;
   logic        abort = 1'b0;
   logic        byteValid;
   logic        byteReady = 1'b0;
   logic [7:0]  byteData;
   logic        pktEnd;
   logic        zlpReq;
   logic        zlpAck = 1'b0;
   logic        done;
   logic        reqError;

   int n_checks = 0;
   int n_fail = 0;

   logic [7:0] byte_q [$];
   logic       end_q [$];
   int done_cnt, err_cnt, zlp_cnt, bv_seen, zlp_before_done;

   // Expected descriptor image, written out by hand from the descriptor layout
   logic [7:0] exp_img [74] = '{
      8'h12, 8'h01, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h08, 8'h34,
      8'h12, 8'h78, 8'h56, 8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h01,
      8'h09, 8'h02, 8'h20, 8'h00, 8'h01, 8'h01, 8'h00, 8'h80, 8'h32,
      8'h09, 8'h04, 8'h00, 8'h00, 8'h02, 8'hFF, 8'h00, 8'h00, 8'h00,
      8'h07, 8'h05, 8'h81, 8'h02, 8'h40, 8'h00, 8'h00,
      8'h07, 8'h05, 8'h02, 8'h02, 8'h40, 8'h00, 8'h00,
      8'h04, 8'h03, 8'h09, 8'h04,
      8'h06, 8'h03, 8'h41, 8'h00, 8'h42, 8'h00,
      8'h08, 8'h03, 8'h55, 8'h00, 8'h53, 8'h00, 8'h42, 8'h00,
      8'h06, 8'h03, 8'h58, 8'h00, 8'h31, 8'h00
   };

   usb_desc_streamer #(.EP0_MAX_PKT(8), .ROM_ADDR_W(8), .NUM_STRINGS(4)) dut (
      .clk48(clk48), .rst_n(rst_n), .reqValid(reqValid), .reqReady(reqReady),
      .reqType(reqType), .reqIdx(reqIdx), .reqLength(reqLength), .abort(abort),
      .byteValid(byteValid), .byteReady(byteReady), .byteData(byteData),
      .pktEnd(pktEnd), .zlpReq(zlpReq), .zlpAck(zlpAck), .done(done),
      .reqError(reqError)
   );

   always #5 clk48 = ~clk48;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [7:0] t, input logic [7:0] i, input logic [15:0] l);
      int waited = 0;
      @(negedge clk48);
      while (!reqReady && waited < 50) begin
         @(negedge clk48);
         waited++;
      end
      if (waited >= 50) check("req_ready_timeout", 64'(reqReady), 64'd1);
      reqType = t; reqIdx = i; reqLength = l; reqValid = 1'b1;
      @(negedge clk48);
      reqValid = 1'b0;
   endtask

   // Runs the stream until done or reqError, auto-acking ZLPs after 2 cycles
   task automatic collect(input bit rnd);
      bit held_v = 1'b0;
      logic [7:0] held_d = 8'h00;
      logic held_e = 1'b0;
      bit fin = 1'b0;
      int zlp_run = 0;
      byte_q.delete(); end_q.delete();
      done_cnt = 0; err_cnt = 0; zlp_cnt = 0; bv_seen = 0; zlp_before_done = 0;
      for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
         if (cyc > 0) @(negedge clk48);
         if (held_v) begin
            check("stall_valid", 64'(byteValid), 64'd1);
            check("stall_data", 64'(byteData), 64'(held_d));
            check("stall_pktend", 64'(pktEnd), 64'(held_e));
         end
         if (byteValid) bv_seen = 1;
         if (reqError) begin err_cnt++; fin = 1'b1; end
         if (done) begin
            done_cnt++;
            if (zlp_cnt > 0) zlp_before_done = 1;
            fin = 1'b1;
         end
         if (zlpReq) begin zlp_cnt++; zlp_run++; end else zlp_run = 0;
         zlpAck = (zlp_run >= 2);
         byteReady = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (byteValid && byteReady) begin
            byte_q.push_back(byteData);
            end_q.push_back(pktEnd);
         end
         held_v = byteValid && !byteReady;
         held_d = byteData;
         held_e = pktEnd;
      end
      if (!fin) check("stream_timeout", 64'd0, 64'd1);
      byteReady = 1'b0;
      zlpAck = 1'b0;
   endtask

   // Compares the captured stream against exp_img[off +: n] and pktEnd on
   // every 8th byte and on the final byte
   task automatic check_stream(input string tag, input int off, input int n);
      logic [63:0] obs_e = 64'd0;
      logic [63:0] exp_e = 64'd0;
      check({tag, "_count"}, 64'(byte_q.size()), 64'(n));
      for (int i = 0; i < n && i < byte_q.size(); i++) begin
         check($sformatf("%s_byte%0d", tag, i), 64'(byte_q[i]), 64'(exp_img[off + i]));
         obs_e[i] = end_q[i];
         exp_e[i] = ((i % 8) == 7) || (i == n - 1);
      end
      check({tag, "_pktend"}, obs_e, exp_e);
   endtask

   initial begin
      // Reset state
      repeat (3) @(posedge clk48);
      @(negedge clk48);
      check("rst_reqReady", 64'(reqReady), 64'd1);
      check("rst_byteValid", 64'(byteValid), 64'd0);
      check("rst_byteData", 64'(byteData), 64'h00);
      check("rst_pktEnd", 64'(pktEnd), 64'd0);
      check("rst_zlpReq", 64'(zlpReq), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_reqError", 64'(reqError), 64'd0);
      rst_n = 1'b1;

      // DEVICE, wLength 64: 18 bytes, no ZLP
      issue(8'h01, 8'h00, 16'd64);
      collect(1'b0);
      check_stream("dev64", 0, 18);
      check("dev64_b0", 64'(byte_q[0]), 64'h12);
      check("dev64_b1", 64'(byte_q[1]), 64'h01);
      check("dev64_zlp", 64'(zlp_cnt), 64'd0);
      check("dev64_done", 64'(done_cnt), 64'd1);
      @(negedge clk48);
      check("dev64_done_pulse", 64'(done), 64'd0);
      check("dev64_ready", 64'(reqReady), 64'd1);

      // DEVICE, wLength 16: truncated, total == wLength so no ZLP
      issue(8'h01, 8'h00, 16'd16);
      collect(1'b0);
      check_stream("dev16", 0, 16);
      check("dev16_zlp", 64'(zlp_cnt), 64'd0);
      check("dev16_done", 64'(done_cnt), 64'd1);

      // CONFIGURATION, wLength 255: 32 bytes, then ZLP, then done
      issue(8'h02, 8'h00, 16'd255);
      collect(1'b0);
      check_stream("cfg255", 18, 32);
      check("cfg255_zlp_cycles", 64'(zlp_cnt), 64'd2);
      check("cfg255_zlp_first", 64'(zlp_before_done), 64'd1);
      check("cfg255_done", 64'(done_cnt), 64'd1);

      // DEVICE_QUALIFIER: unsupported
      issue(8'h06, 8'h00, 16'd10);
      collect(1'b0);
      check("dq_err", 64'(err_cnt), 64'd1);
      check("dq_nobyte", 64'(bv_seen), 64'd0);
      check("dq_nodone", 64'(done_cnt), 64'd0);
      @(negedge clk48);
      check("dq_err_pulse", 64'(reqError), 64'd0);
      check("dq_ready", 64'(reqReady), 64'd1);

      // STRING index NUM_STRINGS: unsupported
      issue(8'h03, 8'h04, 16'd255);
      collect(1'b0);
      check("s4_err", 64'(err_cnt), 64'd1);
      check("s4_nobyte", 64'(bv_seen), 64'd0);
      @(negedge clk48);
      check("s4_err_pulse", 64'(reqError), 64'd0);
      check("s4_ready", 64'(reqReady), 64'd1);

      // STRING 2 with random backpressure: 8 bytes = one full packet -> ZLP
      issue(8'h03, 8'h02, 16'd255);
      collect(1'b1);
      check_stream("s2", 60, 8);
      check("s2_zlp_cycles", 64'(zlp_cnt), 64'd2);
      check("s2_done", 64'(done_cnt), 64'd1);

      // CONFIGURATION, wLength 20, random backpressure: short last packet
      issue(8'h02, 8'h00, 16'd20);
      collect(1'b1);
      check_stream("cfg20", 18, 20);
      check("cfg20_zlp", 64'(zlp_cnt), 64'd0);
      check("cfg20_done", 64'(done_cnt), 64'd1);

      // Zero wLength: straight to ZLP
      issue(8'h01, 8'h00, 16'd0);
      collect(1'b0);
      check("len0_count", 64'(byte_q.size()), 64'd0);
      check("len0_zlp_cycles", 64'(zlp_cnt), 64'd2);
      check("len0_done", 64'(done_cnt), 64'd1);

      // Abort while byte 5 is on the bus
      issue(8'h01, 8'h00, 16'd64);
      begin
         int sent = 0;
         int cyc = 0;
         byteReady = 1'b1;
         while (sent < 5 && cyc < 50) begin
            @(negedge clk48);
            if (byteValid) sent++;
            cyc++;
         end
         check("abort_reach5", 64'(sent), 64'd5);
         @(negedge clk48);
         byteReady = 1'b0;
         check("abort_byte5", 64'(byteData), 64'(exp_img[5]));
         abort = 1'b1;
         @(negedge clk48);
         abort = 1'b0;
         check("abort_valid", 64'(byteValid), 64'd0);
         check("abort_zlp", 64'(zlpReq), 64'd0);
         check("abort_ready", 64'(reqReady), 64'd1);
         cyc = 0;
         for (int i = 0; i < 6; i++) begin
            @(negedge clk48);
            if (done) cyc++;
         end
         check("abort_nodone", 64'(cyc), 64'd0);
      end
      issue(8'h03, 8'h00, 16'd255);
      collect(1'b0);
      check_stream("after_abort", 50, 4);
      check("after_abort_zlp", 64'(zlp_cnt), 64'd0);
      check("after_abort_done", 64'(done_cnt), 64'd1);

      // Abort together with reqValid in IDLE: request ignored
      @(negedge clk48);
      reqType = 8'h01; reqIdx = 8'h00; reqLength = 16'd64;
      reqValid = 1'b1; abort = 1'b1;
      @(negedge clk48);
      reqValid = 1'b0; abort = 1'b0;
      repeat (3) @(negedge clk48);
      check("abort_req_ready", 64'(reqReady), 64'd1);
      check("abort_req_valid", 64'(byteValid), 64'd0);

      // Reset mid-stream: request discarded, no done
      issue(8'h01, 8'h00, 16'd64);
      byteReady = 1'b1;
      repeat (5) @(negedge clk48);
      rst_n = 1'b0;
      @(negedge clk48);
      rst_n = 1'b1;
      byteReady = 1'b0;
      check("rst_mid_valid", 64'(byteValid), 64'd0);
      check("rst_mid_data", 64'(byteData), 64'h00);
      check("rst_mid_ready", 64'(reqReady), 64'd1);
      check("rst_mid_done", 64'(done), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
